// File: rtl/decoder_pkg.sv
// Shared definitions for the registered N-to-2^N decoder: mode encodings,
// FSM states and small elaboration/decode helpers.
package decoder_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_PULSE  = 2'd3
  } state_t;

  // One bit of a one-hot decode; callers loop over positions for any width.
  function automatic logic onehot_bit(input int sel, input int pos);
    return (sel == pos);
  endfunction

  function automatic int cnt_width(input int step_cyc, input int pulse_len);
    int m;
    int w;
    m = (step_cyc > pulse_len) ? step_cyc : pulse_len;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational N-to-2^N one-hot decoder with an enable; all zeros when ena = 0.
module decoder_onehot
  import decoder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    sel,
  input  logic            ena,
  output logic [2**N-1:0] onehot
);

  always_comb begin
    for (int i = 0; i < 2**N; i++) begin
      onehot[i] = ena & onehot_bit(int'(sel), i);
    end
  end

endmodule

// File: rtl/decoder_nx_seq.sv
// Registered N-to-2^N decoder with direct, auto-scan and timed one-shot modes.
//   state     | meaning
//   ST_IDLE   | out inactive, waiting for DIRECT mode or a load strobe
//   ST_DIRECT | out follows onehot(in) with one cycle of latency
//   ST_SCAN   | stepping idx every STEP_CYC cycles, wrapping modulo 2**N
//   ST_PULSE  | holding onehot(idx) for PULSE_LEN cycles, then back to idle
module decoder_nx_seq
  import decoder_pkg::*;
#(
  parameter int N          = 4,
  parameter int STEP_CYC   = 4,
  parameter int PULSE_LEN  = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [N-1:0]    in,
  input  logic            load,
  output logic [2**N-1:0] out,
  output logic [N-1:0]    idx,
  output logic            busy,
  output logic            wrap
);

  localparam int W  = 2**N;
  localparam int CW = cnt_width(STEP_CYC, PULSE_LEN);
  localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);

  state_t         state, state_d;
  logic [N-1:0]   idx_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           on_d, busy_d, wrap_d;
  logic [W-1:0]   dec, out_q;

  // Defaults describe the idle/cleared condition; idx holds unless updated.
  always_comb begin
    state_d = ST_IDLE;
    idx_d   = idx;
    cnt_d   = '0;
    on_d    = 1'b0;
    busy_d  = 1'b0;
    wrap_d  = 1'b0;
    if (en) begin
      case (state)
        ST_IDLE: begin
          if (mode == MODE_DIRECT) begin
            state_d = ST_DIRECT;
            idx_d   = in;
            on_d    = 1'b1;
          end else if ((mode == MODE_SCAN || mode == MODE_PULSE) && load) begin
            state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_PULSE;
            idx_d   = in;
            on_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end
        ST_DIRECT: begin
          if (mode == MODE_DIRECT) begin
            state_d = ST_DIRECT;
            idx_d   = in;
            on_d    = 1'b1;
          end
        end
        ST_SCAN: begin
          if (mode == MODE_SCAN) begin
            state_d = ST_SCAN;
            on_d    = 1'b1;
            busy_d  = 1'b1;
            if (load) begin
              idx_d = in;
            end else if (cnt == STEP_LAST) begin
              idx_d  = idx + 1'b1;
              wrap_d = (idx == '1);
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        end
        ST_PULSE: begin
          // load is deliberately not looked at here, even on the last cycle.
          if (mode == MODE_PULSE && cnt != PULSE_LAST) begin
            state_d = ST_PULSE;
            on_d    = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = cnt + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  decoder_onehot #(.N(N)) u_dec (
    .sel    (idx_d),
    .ena    (on_d),
    .onehot (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      wrap  <= 1'b0;
      out_q <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      busy  <= busy_d;
      wrap  <= wrap_d;
      out_q <= dec;
    end
  end

  assign out = (ACTIVE_LOW != 0) ? ~out_q : out_q;

endmodule

// File: tb/tb_decoder_nx_seq.sv
// Directed bench for decoder_nx_seq: an active-high and an active-low instance
// share stimulus; expected values are hand-computed per scenario.
module tb_decoder_nx_seq;

  logic        clk = 1'b0;
  logic        rst_n, en, load;
  logic [1:0]  mode;
  logic [3:0]  in;
  logic [15:0] out, out2;
  logic [3:0]  idx, idx2;
  logic        busy, wrap, busy2, wrap2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_nx_seq #(.N(4), .STEP_CYC(3), .PULSE_LEN(2), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in), .load(load),
    .out(out), .idx(idx), .busy(busy), .wrap(wrap)
  );

  decoder_nx_seq #(.N(4), .STEP_CYC(3), .PULSE_LEN(2), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in), .load(load),
    .out(out2), .idx(idx2), .busy(busy2), .wrap(wrap2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_block();
    en = 1'b0; load = 1'b0;
    tick();
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; in = 4'h0; load = 1'b0;
    #2;
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL reset_out got=%h exp=%h", out, 16'h0000); end
    total++; if (idx !== 4'h0) begin bad++; $display("FAIL reset_idx got=%h exp=%h", idx, 4'h0); end
    total++; if ({busy, wrap} !== 2'b00) begin bad++; $display("FAIL reset_busy_wrap got=%b exp=%b", {busy, wrap}, 2'b00); end
    total++; if (out2 !== 16'hFFFF) begin bad++; $display("FAIL reset_out_al got=%h exp=%h", out2, 16'hFFFF); end
    #10;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_direct();
    en = 1'b1; mode = 2'b00; in = 4'h5;
    tick();
    total++; if (out !== 16'h0020) begin bad++; $display("FAIL direct_5 got=%h exp=%h", out, 16'h0020); end
    total++; if (idx !== 4'h5 || busy !== 1'b0) begin bad++; $display("FAIL direct_5_idx got=%h/%b exp=5/0", idx, busy); end
    in = 4'hF; load = 1'b1;
    tick();
    load = 1'b0;
    total++; if (out !== 16'h8000) begin bad++; $display("FAIL direct_F got=%h exp=%h", out, 16'h8000); end
    en = 1'b0;
    tick();
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL direct_clear got=%h exp=%h", out, 16'h0000); end
    total++; if (idx !== 4'hF) begin bad++; $display("FAIL direct_clear_idx got=%h exp=%h", idx, 4'hF); end
    en = 1'b1; mode = 2'b01;
    tick();
    total++; if (out !== 16'h0000 || busy !== 1'b0) begin bad++; $display("FAIL scan_noload got=%h/%b exp=0000/0", out, busy); end
  endtask

  task automatic test_scan();
    logic [3:0] e;
    clear_block();
    mode = 2'b01; in = 4'hE; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      e = 4'((14 + k / 3) % 16);
      total++;
      if (idx !== e || out !== (16'h0001 << e) || busy !== 1'b1 || wrap !== (k == 6)) begin
        bad++;
        $display("FAIL scan_step%0d got idx=%h out=%h busy=%b wrap=%b exp idx=%h out=%h busy=1 wrap=%b",
                 k, idx, out, busy, wrap, e, 16'h0001 << e, (k == 6));
      end
      tick();
    end
    in = 4'h7; load = 1'b1;
    tick();
    load = 1'b0;
    total++; if (idx !== 4'h7 || wrap !== 1'b0) begin bad++; $display("FAIL scan_restart got=%h/%b exp=7/0", idx, wrap); end
    tick(); tick();
    total++; if (idx !== 4'h7) begin bad++; $display("FAIL scan_restart_hold got=%h exp=%h", idx, 4'h7); end
    tick();
    total++; if (idx !== 4'h8) begin bad++; $display("FAIL scan_restart_step got=%h exp=%h", idx, 4'h8); end
    in = 4'h0; load = 1'b1;
    tick();
    load = 1'b0;
    total++; if (idx !== 4'h0 || wrap !== 1'b0 || out !== 16'h0001) begin bad++; $display("FAIL scan_load0 got=%h/%b/%h exp=0/0/0001", idx, wrap, out); end
  endtask

  task automatic test_pulse();
    clear_block();
    mode = 2'b10; in = 4'h3; load = 1'b1;
    tick();
    in = 4'h9;
    total++; if (out !== 16'h0008 || busy !== 1'b1) begin bad++; $display("FAIL pulse_c1 got=%h/%b exp=0008/1", out, busy); end
    tick();
    total++; if (out !== 16'h0008 || busy !== 1'b1 || idx !== 4'h3) begin bad++; $display("FAIL pulse_c2 got=%h/%b/%h exp=0008/1/3", out, busy, idx); end
    tick();
    total++; if (out !== 16'h0000 || busy !== 1'b0) begin bad++; $display("FAIL pulse_end got=%h/%b exp=0000/0", out, busy); end
    tick();
    load = 1'b0;
    total++; if (out !== 16'h0200 || busy !== 1'b1 || idx !== 4'h9) begin bad++; $display("FAIL pulse_reload got=%h/%b/%h exp=0200/1/9", out, busy, idx); end
    tick(); tick();
    total++; if (out !== 16'h0000 || busy !== 1'b0) begin bad++; $display("FAIL pulse_reload_end got=%h/%b exp=0000/0", out, busy); end
  endtask

  task automatic test_abort();
    clear_block();
    mode = 2'b01; in = 4'h7; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    mode = 2'b10;
    tick();
    total++; if (out !== 16'h0000 || busy !== 1'b0 || wrap !== 1'b0) begin bad++; $display("FAIL abort got=%h/%b/%b exp=0000/0/0", out, busy, wrap); end
    in = 4'h2; load = 1'b1;
    tick();
    load = 1'b0;
    total++; if (out !== 16'h0004 || busy !== 1'b1) begin bad++; $display("FAIL abort_pulse1 got=%h/%b exp=0004/1", out, busy); end
    tick();
    total++; if (out !== 16'h0004 || busy !== 1'b1) begin bad++; $display("FAIL abort_pulse2 got=%h/%b exp=0004/1", out, busy); end
    tick();
    total++; if (out !== 16'h0000 || busy !== 1'b0) begin bad++; $display("FAIL abort_pulse_end got=%h/%b exp=0000/0", out, busy); end
  endtask

  task automatic test_async_reset();
    clear_block();
    mode = 2'b10; in = 4'h5; load = 1'b1;
    tick();
    load = 1'b0;
    total++; if (out !== 16'h0020 || busy !== 1'b1) begin bad++; $display("FAIL areset_pre got=%h/%b exp=0020/1", out, busy); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out !== 16'h0000 || busy !== 1'b0 || idx !== 4'h0 || wrap !== 1'b0) begin
      bad++; $display("FAIL areset_mid got=%h/%b/%h/%b exp=0000/0/0/0", out, busy, idx, wrap);
    end
    total++; if (out2 !== 16'hFFFF) begin bad++; $display("FAIL areset_mid_al got=%h exp=%h", out2, 16'hFFFF); end
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_active_low();
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; in = 4'h0; load = 1'b0;
    #1;
    total++; if (out2 !== 16'hFFFF) begin bad++; $display("FAIL al_reset got=%h exp=%h", out2, 16'hFFFF); end
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    tick();
    total++; if (out2 !== 16'hFFFE) begin bad++; $display("FAIL al_direct0 got=%h exp=%h", out2, 16'hFFFE); end
    mode = 2'b11; in = 4'h4; load = 1'b1;
    tick();
    total++; if (out2 !== 16'hFFFF) begin bad++; $display("FAIL al_leave_direct got=%h exp=%h", out2, 16'hFFFF); end
    tick();
    load = 1'b0;
    total++; if (out2 !== 16'hFFFF || busy2 !== 1'b0) begin bad++; $display("FAIL al_rsvd got=%h/%b exp=FFFF/0", out2, busy2); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_pulse();
    test_abort();
    test_async_reset();
    test_active_low();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
